// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings (same as the target TAP
// controller), scan command opcodes, master FSM states and the standard
// 16-state TAP next-state function. No ports; imported by the master files.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_IR    = 2'b01,
    OP_DR    = 2'b10,
    OP_IDLE  = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_READY,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } mst_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
      default:          return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: one bit period = CLK_DIV cycles low then CLK_DIV cycles high.
// Latency: TCK registered; rise/fall are combinational strobes for the edge that raises/ends the period.
// Backpressure: none; counts only while run is high, otherwise parked at period start with TCK low.
// Ports: clk, TRST (async active-low), run in; tck, rise, fall out.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic TRST,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign rise = run && (cnt == RISE_AT);
  // fall marks the last cycle of a period; the next edge starts a new low phase
  assign fall = run && (cnt == FALL_AT);

  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run || fall) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (rise) tck <= 1'b1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG master: walks a target TAP through reset, IR/DR scans and idle cycles.
// Latency: DR N+5, IR N+6, reset 6, idle cmd_len bit periods of 2*CLK_DIV clk, then a 1-cycle rsp_valid.
// Backpressure: cmd_ready low while busy; responses are not backpressured.
// Ports: clk, TRST (async active-low); cmd_valid/ready/op/len/data command in;
//        rsp_valid/rsp_data response out; TCK/TMS/TDI out, TDO in;
//        tap_state out only when JTAG_MASTER_TAP_TRACK_EN is defined (TAP state mirror).
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
`ifdef JTAG_MASTER_TAP_TRACK_EN
  ,
  output logic [3:0]         tap_state
`endif
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  mst_state_t         state, state_nxt;
  logic [5:0]         cnt, cnt_nxt;
  cmd_op_t            op_q, op_eff;
  logic [5:0]         n_q, n_eff, n_cmd;
  logic [MAX_LEN-1:0] data_q, rsp_q;
  logic               tms_q, tdi_q;
  logic               accept, run, rise, fall;

  // Index of the last bit period in the current phase.
  function automatic logic [5:0] last_idx(input mst_state_t st, input cmd_op_t op,
                                          input logic [5:0] n);
    case (st)
      ST_INIT:  return 6'd5;
      ST_PRE: begin
        case (op)
          OP_RESET: return 6'd5;
          OP_IR:    return 6'd3;
          OP_DR:    return 6'd2;
          default:  return n - 6'd1;
        endcase
      end
      ST_SHIFT: return n - 6'd1;
      ST_POST:  return 6'd1;
      default:  return 6'd0;
    endcase
  endfunction

  // TMS for bit period cnt of phase st. PRE doubles as the body of reset/idle commands.
  function automatic logic tms_for(input mst_state_t st, input cmd_op_t op,
                                   input logic [5:0] c, input logic [5:0] n);
    case (st)
      ST_INIT: return c != 6'd5;
      ST_PRE: begin
        case (op)
          OP_RESET: return c != 6'd5;
          OP_IR:    return c < 6'd2;
          OP_DR:    return c == 6'd0;
          default:  return 1'b0;
        endcase
      end
      ST_SHIFT: return c == n - 6'd1;
      ST_POST:  return c == 6'd0;
      default:  return 1'b0;
    endcase
  endfunction

  // Scans shift at least one bit and at most MAX_LEN; idle uses the raw count.
  always_comb begin
    n_cmd = cmd_len;
    if (cmd_op != OP_IDLE) begin
      if (cmd_len == 6'd0)                n_cmd = 6'd1;
      else if (int'(cmd_len) > MAX_LEN)   n_cmd = 6'(MAX_LEN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_eff    = op_q;
    n_eff     = n_q;
    accept    = 1'b0;
    case (state)
      ST_READY, ST_DONE: begin
        state_nxt = ST_READY;
        if (cmd_valid) begin
          accept    = 1'b1;
          op_eff    = cmd_op_t'(cmd_op);
          n_eff     = n_cmd;
          cnt_nxt   = 6'd0;
          // zero-length idle finishes without a single TCK period
          state_nxt = (op_eff == OP_IDLE && n_eff == 6'd0) ? ST_DONE : ST_PRE;
        end
      end
      default: begin
        if (fall) begin
          if (cnt == last_idx(state, op_q, n_q)) begin
            cnt_nxt = 6'd0;
            case (state)
              ST_INIT:  state_nxt = ST_READY;
              ST_PRE:   state_nxt = (op_q == OP_IR || op_q == OP_DR) ? ST_SHIFT : ST_DONE;
              ST_SHIFT: state_nxt = ST_POST;
              default:  state_nxt = ST_DONE;
            endcase
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
    endcase
  end

  assign run       = (state == ST_INIT) || (state == ST_PRE) ||
                     (state == ST_SHIFT) || (state == ST_POST);
  assign cmd_ready = (state == ST_READY) || (state == ST_DONE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  // TMS/TDI are evaluated for the upcoming period every cycle; they only move
  // when state/cnt move, i.e. on the edge that begins a low phase.
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      state  <= ST_INIT;
      cnt    <= 6'd0;
      op_q   <= OP_RESET;
      n_q    <= 6'd0;
      data_q <= '0;
      rsp_q  <= '0;
      tms_q  <= 1'b1;
      tdi_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_eff;
      n_q   <= n_eff;
      tms_q <= tms_for(state_nxt, op_eff, cnt_nxt, n_eff);
      tdi_q <= (state_nxt == ST_SHIFT) ? data_q[cnt_nxt[IW-1:0]] : 1'b0;
      if (accept) begin
        data_q <= cmd_data;
        rsp_q  <= '0;
      end else if (rise && state == ST_SHIFT) begin
        rsp_q[cnt[IW-1:0]] <= TDO;
      end
    end
  end

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk  (clk),
    .TRST (TRST),
    .run  (run),
    .tck  (TCK),
    .rise (rise),
    .fall (fall)
  );

`ifdef JTAG_MASTER_TAP_TRACK_EN
  tap_state_t tap_q;

  // target sees TMS on TCK rising, which is exactly the rise strobe edge
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST)     tap_q <= TEST_LOGIC_RESET;
    else if (rise) tap_q <= tap_next(tap_q, tms_q);
  end

  assign tap_state = tap_q;
`endif

endmodule
